// File: rtl/lfsr_prime_pkg.sv
// Shared types and constants for the LFSR prime picker: state encoding,
// LFSR taps (x^7 + x^6 + 1), and a 128-entry prime lookup mask.
package lfsr_prime_pkg;

    localparam int unsigned WIDTH      = 7;
    localparam int unsigned NUM_VALUES = 1 << WIDTH;
    localparam int unsigned TAP_HI     = 6;
    localparam int unsigned TAP_LO     = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    // Bit n is set when n is prime; built by trial division at elaboration.
    function automatic logic [NUM_VALUES-1:0] build_prime_mask();
        logic [NUM_VALUES-1:0] mask;
        logic                  is_p;
        mask = '0;
        for (int unsigned n = 2; n < NUM_VALUES; n++) begin
            is_p = 1'b1;
            for (int unsigned d = 2; d * d <= n; d++) begin
                if ((n % d) == 0) is_p = 1'b0;
            end
            mask[n[WIDTH-1:0]] = is_p;
        end
        return mask;
    endfunction

    localparam logic [NUM_VALUES-1:0] PRIME_MASK = build_prime_mask();

    // One Fibonacci step: shift left, feed back tap6 ^ tap5.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_prime_check.sv
// Combinational primality test for a 7-bit value via the package mask.
module lfsr_prime_check
    import lfsr_prime_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    output logic             is_prime_c
);

    // Table lookup; 0 and 1 are clear in the mask.
    assign is_prime_c = PRIME_MASK[value];

endmodule

// File: rtl/lfsr_prime_picker.sv
// Pseudo-random prime picker: on enable, latches score as an upper bound and
// walks a 7-bit maximal-length LFSR until a prime p, 2 <= p <= bound, appears.
// Build option: define LFSR_PRIME_FREERUN_EN to let the LFSR also advance
// while idle (results then depend on request timing).
module lfsr_prime_picker #(
    parameter int unsigned WIDTH = 7,
    parameter logic [6:0]  SEED  = 7'h5A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] score,
    output logic [WIDTH-1:0] primeNumberOutput
);

    import lfsr_prime_pkg::state_t;
    import lfsr_prime_pkg::IDLE;
    import lfsr_prime_pkg::SEARCH;
    import lfsr_prime_pkg::lfsr_step;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] bound_nxt;
    logic [WIDTH-1:0] prime_nxt;
    logic             cand_is_prime_c;

    lfsr_prime_check u_check (
        .value      (lfsr),
        .is_prime_c (cand_is_prime_c)
    );

    // State, LFSR, bound and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lfsr              <= SEED;
            bound             <= '0;
            primeNumberOutput <= '0;
        end else begin
            state             <= state_nxt;
            lfsr              <= lfsr_nxt;
            bound             <= bound_nxt;
            primeNumberOutput <= prime_nxt;
        end
    end

    // Next-state: capture request in IDLE, scan LFSR candidates in SEARCH.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        bound_nxt = bound;
        prime_nxt = primeNumberOutput;

        case (state)
            IDLE: begin
`ifdef LFSR_PRIME_FREERUN_EN
                lfsr_nxt = lfsr_step(lfsr);
`endif
                if (enable) begin
                    bound_nxt = score;
                    if (score < WIDTH'(2)) begin
                        prime_nxt = '0;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            SEARCH: begin
                // The LFSR advances on every search cycle, hit included.
                lfsr_nxt = lfsr_step(lfsr);
                if (cand_is_prime_c && (lfsr <= bound)) begin
                    prime_nxt = lfsr;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_prime_picker.sv
// Scoreboard bench for lfsr_prime_picker: stimulus pushes expected primes,
// a negedge monitor pops and compares on every SEARCH->IDLE completion and
// checks the output holds steady otherwise.
module tb_lfsr_prime_picker;
    import lfsr_prime_pkg::*;

    localparam logic [6:0] TB_SEED = 7'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] score;
    logic [6:0] prime_out;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         zero_seen = 0;
    logic [6:0] exp_q[$];
    logic [6:0] model_lfsr;
    bit         rst_window   = 1'b1;
    bit         allow_change = 1'b0;
    logic [6:0] prev_out;
    state_t     prev_st;
    logic [6:0] p;

    int primes [31] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47,
                        53, 59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107,
                        109, 113, 127};

    lfsr_prime_picker dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .score             (score),
        .primeNumberOutput (prime_out)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_prime(input logic [6:0] v);
        foreach (primes[i]) if (primes[i] == int'(v)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    task automatic m_search(input logic [6:0] b, output logic [6:0] res);
        logic [6:0] c;
        res = 7'd0;
        for (int k = 0; k < 200; k++) begin
            c = model_lfsr;
            model_lfsr = m_step(model_lfsr);
            if (m_is_prime(c) && c <= b) begin
                res = c;
                return;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic request(input logic [6:0] s);
        @(posedge clk); #2;
        enable = 1'b1;
        score  = s;
        @(posedge clk); #2;
        enable = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: compare on completion, otherwise require a steady output.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_window) begin
                if (dut.lfsr == 7'd0) zero_seen++;
                if (prev_st == SEARCH && dut.state == IDLE) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", int'(prime_out), -1);
                    end else begin
                        check("result", int'(prime_out), int'(exp_q.pop_front()));
                    end
                end else if (allow_change) begin
                    allow_change = 1'b0;
                end else begin
                    check("stable", int'(prime_out), int'(prev_out));
                end
            end
            prev_out = prime_out;
            prev_st  = dut.state;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        score  = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(prime_out), 0);
        check("reset_lfsr", int'(dut.lfsr), int'(TB_SEED));
        #1;
        rst        = 1'b0;
        model_lfsr = TB_SEED;
        rst_window = 1'b0;

        // Idle: nothing moves.
        repeat (10) @(posedge clk);
        #2;
        check("idle_out", int'(prime_out), 0);
        check("idle_lfsr_hold", int'(dut.lfsr), int'(TB_SEED));

        // score=15 from seed: candidates 90,53,...,70,13 -> 13.
        m_search(7'd15, p);
        exp_q.push_back(7'd13);
        request(7'd15);
        wait_done("first");
        repeat (150) @(posedge clk);

        // score=31 continues from 26: 26,52,105,82,37,75,23 -> 23; enable
        // pulses mid-search must be ignored.
        m_search(7'd31, p);
        exp_q.push_back(7'd23);
        request(7'd31);
        repeat (2) @(posedge clk);
        #2;
        enable = 1'b1;
        score  = 7'd3;
        @(posedge clk);
        @(posedge clk);
        #2;
        enable = 1'b0;
        wait_done("second");

        // score<2 clears the output and stays idle.
        request(7'd1);
        allow_change = 1'b1;
        check("score1_out", int'(prime_out), 0);
        check("score1_idle", int'(dut.state), int'(IDLE));
        request(7'd0);
        allow_change = 1'b1;
        check("score0_out", int'(prime_out), 0);
        check("score0_idle", int'(dut.state), int'(IDLE));
        repeat (3) @(posedge clk);

        // Burst of full-range requests against the model.
        for (int r = 0; r < 200; r++) begin
            m_search(7'd127, p);
            exp_q.push_back(p);
            request(7'd127);
            wait_done("burst");
        end
        check("lfsr_never_zero", zero_seen, 0);

        // Reset back to seed, get 13, then abort a search with reset.
        @(posedge clk); #2;
        rst_window = 1'b1;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst        = 1'b0;
        model_lfsr = TB_SEED;
        rst_window = 1'b0;
        m_search(7'd15, p);
        exp_q.push_back(7'd13);
        request(7'd15);
        wait_done("pre_abort");
        request(7'd31);
        @(posedge clk);
        #1;
        rst_window = 1'b1;
        rst        = 1'b1;
        #1;
        check("abort_out", int'(prime_out), 0);
        check("abort_lfsr", int'(dut.lfsr), int'(TB_SEED));
        check("abort_state", int'(dut.state), int'(IDLE));
        repeat (2) @(posedge clk);
        #2;
        rst        = 1'b0;
        model_lfsr = TB_SEED;
        rst_window = 1'b0;
        m_search(7'd15, p);
        exp_q.push_back(7'd13);
        request(7'd15);
        wait_done("after_abort");
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
